// File: rtl/pc_int_sequencer.sv
// Program counter, condition flag and prioritised, nestable interrupt sequencer for jacaranda-8.
// Define PC_SEQ_NESTING_EN for multi-level nesting and preemption; otherwise a single ISR level is used.
module pc_int_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int N_IRQ       = 4,
  parameter int STACK_DEPTH = 2,
  parameter int VEC_STRIDE  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_jmpEn,
  input  logic              i_jeEn,
  input  logic              i_ret,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_flagWEn,
  input  logic              i_flagWData,
  input  logic              i_gie,
  input  logic [N_IRQ-1:0]  i_irqReq,
  input  logic [N_IRQ-1:0]  i_irqMask,
  input  logic [ADDR_W-1:0] i_vecBase,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_flag,
  output logic [N_IRQ-1:0]  o_intAck,
  output logic              o_inIsr,
  output logic [2:0]        o_depth,
  output logic              o_stackErr
);

`ifdef PC_SEQ_NESTING_EN
  localparam int EFF_DEPTH = STACK_DEPTH;
`else
  // Single-level mode ignores STACK_DEPTH; both arms of the select give one entry.
  localparam int EFF_DEPTH = (STACK_DEPTH > 1) ? 1 : 1;
`endif

  localparam int PW = $clog2(N_IRQ + 1);
  localparam int EW = ADDR_W + 1 + PW;
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(VEC_STRIDE);

  logic [ADDR_W-1:0] r_pc;
  logic              r_flag;
  logic [PW-1:0]     r_curPrio;
  logic [2:0]        r_depth;
  logic [N_IRQ-1:0]  r_intAck;
  logic              r_stackErr;
  logic [EW-1:0]     r_stack [EFF_DEPTH];

  logic [N_IRQ-1:0]  w_pending;
  logic [PW-1:0]     w_winner;
  logic              w_take;
  logic [ADDR_W-1:0] w_pcInc;
  logic [ADDR_W-1:0] w_nextPc;
  logic [ADDR_W-1:0] w_vecPc;
  logic [N_IRQ-1:0]  w_ackVec;
  logic [EW-1:0]     w_push;
  logic [EW-1:0]     w_top;

  assign w_pending = i_irqReq & i_irqMask;

  // Lowest pending index wins; N_IRQ means nothing pending and never beats cur_prio.
  always_comb begin
    w_winner = PW'(N_IRQ);
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_pending[i]) w_winner = PW'(i);
    end
  end

  assign w_take   = i_gie & ~i_ret & (w_winner < r_curPrio) & (r_depth < 3'(EFF_DEPTH));
  assign w_pcInc  = r_pc + 1'b1;
  assign w_nextPc = (i_jmpEn | (i_jeEn & r_flag)) ? i_target : w_pcInc;
  assign w_vecPc  = i_vecBase + ADDR_W'(w_winner) * STRIDE_A;
  assign w_ackVec = N_IRQ'(1) << w_winner;
  assign w_push   = {w_nextPc, r_flag, r_curPrio};

  always_comb begin
    w_top = '0;
    for (int e = 0; e < EFF_DEPTH; e++) begin
      if (r_depth == 3'(e + 1)) w_top = r_stack[e];
    end
  end

  // Stack contents carry no reset; only the depth counter decides what is valid.
  always_ff @(posedge clock) begin
    if (w_take) begin
      for (int e = 0; e < EFF_DEPTH; e++) begin
        if (r_depth == 3'(e)) r_stack[e] <= w_push;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc       <= '0;
      r_flag     <= 1'b0;
      r_curPrio  <= PW'(N_IRQ);
      r_depth    <= '0;
      r_intAck   <= '0;
      r_stackErr <= 1'b0;
    end else begin
      r_intAck <= w_take ? w_ackVec : '0;
      if (w_take) begin
        r_pc      <= w_vecPc;
        r_flag    <= 1'b0;
        r_curPrio <= w_winner;
        r_depth   <= r_depth + 3'd1;
      end else if (i_ret) begin
        if (r_depth != 3'd0) begin
          r_pc      <= w_top[EW-1 -: ADDR_W];
          r_flag    <= w_top[PW];
          r_curPrio <= w_top[PW-1:0];
          r_depth   <= r_depth - 3'd1;
        end else begin
          r_pc       <= w_pcInc;
          r_stackErr <= 1'b1;
        end
      end else if (i_jeEn && !i_jmpEn) begin
        r_pc   <= r_flag ? i_target : w_pcInc;
        r_flag <= 1'b0;
      end else begin
        r_pc <= i_jmpEn ? i_target : w_pcInc;
        if (i_flagWEn) r_flag <= i_flagWData;
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_flag     = r_flag;
  assign o_intAck   = r_intAck;
  assign o_depth    = r_depth;
  assign o_inIsr    = (r_depth != 3'd0);
  assign o_stackErr = r_stackErr;

endmodule
